wind_lights_n: RTL and testbench

- Parametrised runway wind-indicator light driver. Successor to the fixed 3-light pattern FSM.
- Drives N_LIGHTS lamps from the 2-bit wind code w. Supports a calm pattern, two sweep directions and a flash mode.
- A programmable step prescaler sets the pattern speed; a hold input freezes the pattern.
- Sits between the switch/wind-sensor inputs and the LED output pins.

---
 rtl/wind_lights_n_pkg.sv | 21 ++
 rtl/wind_lights_n_if.sv | 15 +
 rtl/wind_lights_n_step_prescaler.sv | 32 +++
 rtl/wind_lights_n.sv | 75 +++++++
 tb/tb_wind_lights_n.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/wind_lights_n_pkg.sv
// Shared types for the runway wind-indicator light driver.
// Mode encoding matches the wind code so w can be cast straight to a mode.
package wind_lights_pkg;

  typedef enum logic [1:0] {
    MODE_CALM    = 2'b00,
    MODE_SWEEP_L = 2'b01,
    MODE_SWEEP_R = 2'b10,
    MODE_FLASH   = 2'b11
  } mode_e;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  function automatic mode_e modeFromCode(input logic [1:0] code);
    return mode_e'(code);
  endfunction

endpackage

// File: rtl/wind_lights_n_if.sv
// Switch/sensor inputs and lamp outputs of the wind-indicator driver.
// The master side drives w/speed/hold; the slave side is the light driver.
interface wind_lights_n_if #(
  parameter int N_LIGHTS = 5,
  parameter int DIV_W    = 8
);
  logic [1:0]          w;
  logic [DIV_W-1:0]    speed;
  logic                hold;
  logic [N_LIGHTS-1:0] out;
  logic                step_o;

  modport master (output w, speed, hold, input out, step_o);
  modport slave  (input w, speed, hold, output out, step_o);
endinterface

// File: rtl/wind_lights_n_step_prescaler.sv
// Pattern-speed prescaler: emits a step every speed_i+1 cycles, frozen by hold_i.
module step_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] speed_i,
  input  logic             hold_i,
  output logic             step_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // ">=" rather than "==" so a speed lowered below the running count steps at once
  assign step_o = !hold_i && (cnt_q >= speed_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wind_lights_n.sv
// Runway wind-indicator light driver: calm, sweep-left, sweep-right and flash
// patterns on N_LIGHTS lamps, advanced by a programmable step prescaler.
module wind_lights_n
  import wind_lights_pkg::*;
#(
  parameter int N_LIGHTS = 5,
  parameter int DIV_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  wind_lights_n_if.slave  bus
);

  localparam int                  C          = (N_LIGHTS - 1) / 2;
  localparam logic [N_LIGHTS-1:0] PAT_LSB    = {{(N_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [N_LIGHTS-1:0] PAT_MSB    = PAT_LSB << (N_LIGHTS - 1);
  localparam logic [N_LIGHTS-1:0] PAT_CENTRE = PAT_LSB << C;
  localparam logic [N_LIGHTS-1:0] PAT_EDGES  = PAT_LSB | PAT_MSB;

  logic                stepPulse;
  mode_e               mode_q, mode_d;
  phase_e              phase_q;
  logic [N_LIGHTS-1:0] out_q;
  logic                step_q;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .speed_i (bus.speed),
    .hold_i  (bus.hold),
    .step_o  (stepPulse)
  );

  assign mode_d = modeFromCode(bus.w);

  // A step with a changed wind code loads the new mode's entry pattern instead of advancing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_CALM;
      phase_q <= PH_A;
      out_q   <= PAT_CENTRE;
      step_q  <= 1'b0;
    end else begin
      step_q <= stepPulse;
      if (stepPulse) begin
        mode_q <= mode_d;
        if (mode_d != mode_q) begin
          phase_q <= PH_A;
          case (mode_d)
            MODE_CALM:    out_q <= PAT_CENTRE;
            MODE_SWEEP_L: out_q <= PAT_LSB;
            MODE_SWEEP_R: out_q <= PAT_MSB;
            MODE_FLASH:   out_q <= '1;
            default:      out_q <= PAT_CENTRE;
          endcase
        end else begin
          case (mode_q)
            MODE_CALM: begin
              phase_q <= (phase_q == PH_A) ? PH_B : PH_A;
              out_q   <= (phase_q == PH_A) ? PAT_EDGES : PAT_CENTRE;
            end
            MODE_SWEEP_L: out_q <= {out_q[N_LIGHTS-2:0], out_q[N_LIGHTS-1]};
            MODE_SWEEP_R: out_q <= {out_q[0], out_q[N_LIGHTS-1:1]};
            MODE_FLASH:   out_q <= (out_q == '0) ? '1 : '0;
            default:      out_q <= PAT_CENTRE;
          endcase
        end
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.step_o = step_q;

endmodule

// File: tb/tb_wind_lights_n.sv
// Directed scoreboard bench for wind_lights_n with N_LIGHTS=5, DIV_W=8.
module tb_wind_lights_n;

  logic clk;
  logic reset;

  wind_lights_n_if #(.N_LIGHTS(5), .DIV_W(8)) bus ();

  wind_lights_n #(.N_LIGHTS(5), .DIV_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0] outExp;
    logic       stepExp;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] wIn, input logic [7:0] speedIn, input logic holdIn);
    bus.w     = wIn;
    bus.speed = speedIn;
    bus.hold  = holdIn;
  endtask

  task automatic pushExp(input logic [4:0] o, input logic s, input string tag);
    exp_t e;
    e.outExp  = o;
    e.stepExp = s;
    e.tag     = tag;
    expQ.push_back(e);
  endtask

  // Pops one expectation and compares it; waitEdge samples 1 ns after the next rising edge
  task automatic checkOutput(input bit waitEdge);
    exp_t e;
    if (waitEdge) begin
      @(posedge clk);
      #1;
    end
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL queue_empty: got no expectation, required one");
      return;
    end
    e = expQ.pop_front();
    compared++;
    assert (bus.out === e.outExp) else begin
      mismatched++;
      $display("[TB] FAIL %s out: got %b required %b", e.tag, bus.out, e.outExp);
      $error("[TB] check %s out", e.tag);
    end
    compared++;
    assert (bus.step_o === e.stepExp) else begin
      mismatched++;
      $display("[TB] FAIL %s step_o: got %b required %b", e.tag, bus.step_o, e.stepExp);
      $error("[TB] check %s step_o", e.tag);
    end
  endtask

  task automatic expectCycle(input logic [4:0] o, input logic s, input string tag);
    pushExp(o, s, tag);
    checkOutput(1'b1);
  endtask

  initial begin
    logic [4:0] slSeq[6];
    logic [4:0] srSeq[6];
    logic [4:0] prev;

    slSeq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    srSeq = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

    reset = 1'b1;
    applyStimulus(2'b00, 8'd0, 1'b0);
    expectCycle(5'b00100, 1'b0, "reset");

    reset = 1'b0;
    expectCycle(5'b10001, 1'b1, "calm_b1");
    expectCycle(5'b00100, 1'b1, "calm_a");
    expectCycle(5'b10001, 1'b1, "calm_b2");

    applyStimulus(2'b01, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) expectCycle(slSeq[i], 1'b1, "sweep_l");

    applyStimulus(2'b10, 8'd3, 1'b0);
    prev = 5'b00001;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) expectCycle(prev, 1'b0, "sweep_r_wait");
      expectCycle(srSeq[i], 1'b1, "sweep_r_step");
      prev = srSeq[i];
    end

    applyStimulus(2'b10, 8'd7, 1'b0);
    for (int k = 0; k < 5; k++) expectCycle(5'b10000, 1'b0, "speed7_count");
    applyStimulus(2'b10, 8'd2, 1'b0);
    expectCycle(5'b01000, 1'b1, "speed_lowered");

    applyStimulus(2'b10, 8'd2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus.w = 2'b11;
      if (k == 6) bus.w = 2'b10;
      expectCycle(5'b01000, 1'b0, "hold");
    end
    applyStimulus(2'b10, 8'd2, 1'b0);
    expectCycle(5'b01000, 1'b0, "unhold_wait");
    expectCycle(5'b01000, 1'b0, "unhold_wait");
    expectCycle(5'b00100, 1'b1, "unhold_step");

    applyStimulus(2'b11, 8'd0, 1'b0);
    expectCycle(5'b11111, 1'b1, "flash_on");
    expectCycle(5'b00000, 1'b1, "flash_off");
    expectCycle(5'b11111, 1'b1, "flash_on2");
    applyStimulus(2'b00, 8'd0, 1'b0);
    expectCycle(5'b00100, 1'b1, "flash_to_calm");

    applyStimulus(2'b01, 8'd0, 1'b0);
    expectCycle(5'b00001, 1'b1, "pre_reset_sl");
    expectCycle(5'b00010, 1'b1, "pre_reset_sl");
    #2;
    reset = 1'b1;
    bus.w = 2'b00;
    #1;
    pushExp(5'b00100, 1'b0, "async_reset");
    checkOutput(1'b0);
    expectCycle(5'b00100, 1'b0, "reset_held");
    reset = 1'b0;
    expectCycle(5'b10001, 1'b1, "post_reset_calm_b");
    expectCycle(5'b00100, 1'b1, "post_reset_calm_a");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
